// File: rtl/calc_pkg.sv
// calc_pkg: shared key codes, operator codes, states and
// display selector codes for the calculator core.
package calc_pkg;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_CLR = 4'hC;
  localparam logic [3:0] KEY_EQ  = 4'hD;
  localparam logic [3:0] KEY_MUL = 4'hE;
  localparam logic [3:0] KEY_BS  = 4'hF;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_MUL  = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    S_OP1,
    S_OPER,
    S_OP2,
    S_CALC,
    S_RES,
    S_ERR
  } state_t;

  localparam logic [1:0] SEL_ZERO = 2'b00;
  localparam logic [1:0] SEL_OP1  = 2'b01;
  localparam logic [1:0] SEL_OPER = 2'b10;
  localparam logic [1:0] SEL_OP2  = 2'b11;

  function automatic op_t key_op(input logic [3:0] k);
    op_t o;
    o = OP_NONE;
    unique case (1'b1)
      k == KEY_ADD: o = OP_ADD;
      k == KEY_SUB: o = OP_SUB;
      k == KEY_MUL: o = OP_MUL;
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/calc_if.sv
// calc_if: key event input and registered display outputs
// between the keypad chain, the core and the display.
interface calc_if #(
  parameter int W = 14
);
  logic         key_valid;
  logic [3:0]   key_code;
  logic [W-1:0] disp_value;
  logic         disp_neg;
  logic [1:0]   disp_op;
  logic [1:0]   disp_sel;
  logic         busy;
  logic         res_valid;
  logic         err;

  modport master (
    output key_valid, key_code,
    input  disp_value, disp_neg, disp_op,
    input  disp_sel, busy, res_valid, err
  );

  modport slave (
    input  key_valid, key_code,
    output disp_value, disp_neg, disp_op,
    output disp_sel, busy, res_valid, err
  );
endinterface

// File: rtl/calc_mul_seq.sv
// calc_mul_seq: shift-add multiplier, one multiplier bit
// per cycle, done pulses after W iterations.
module calc_mul_seq #(
  parameter int W = 14
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clr,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p,
  output logic           done
);
  localparam int IW = $clog2(W);
  localparam logic [IW-1:0] LAST = IW'(W - 1);

  logic [2*W-1:0] a_sh;
  logic [W-1:0]   b_sh;
  logic [IW-1:0]  idx;
  logic           run;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sh <= '0;
      b_sh <= '0;
      idx  <= '0;
      run  <= 1'b0;
      p    <= '0;
      done <= 1'b0;
    end else if (clr) begin
      idx  <= '0;
      run  <= 1'b0;
      p    <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !run) begin
        a_sh <= {{W{1'b0}}, a};
        b_sh <= b;
        idx  <= '0;
        p    <= '0;
        run  <= 1'b1;
      end else if (run) begin
        if (b_sh[0]) p <= p + a_sh;
        a_sh <= a_sh << 1;
        b_sh <= b_sh >> 1;
        idx  <= idx + 1'b1;
        if (idx == LAST) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/calc_core.sv
// calc_core: keypad-driven decimal calculator controller
// with add/sub and a sequential multiplier.
module calc_core
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = 4,
  parameter int W = 14
) (
  input logic   clk,
  input logic   reset,
  calc_if.slave io
);
  localparam int MAX_VAL = 10 ** MAX_DIGITS - 1;
  localparam int CW = $clog2(MAX_DIGITS + 1);
  typedef logic [W-1:0] val_t;
  typedef logic [CW-1:0] cnt_t;
  localparam val_t TEN = val_t'(10);
  localparam cnt_t CMAX = cnt_t'(MAX_DIGITS);
  localparam logic [W:0] SMAX = (W+1)'(MAX_VAL);
  localparam logic [2*W-1:0] PMAX = (2*W)'(MAX_VAL);

  if ((64'd1 << W) <= 64'(MAX_VAL)) begin : g_bad_w
    $error("calc_core: W too small for MAX_DIGITS");
  end

  state_t st, st_n;
  val_t op1, op1_n, op2, op2_n, res, res_n;
  val_t val_n, d, diff;
  cnt_t cnt1, cnt1_n, cnt2, cnt2_n;
  op_t op, op_n;
  logic neg, neg_n, rv_n, lt;
  logic [1:0] sel_n;
  logic dig, opk, eq_k, bs_k, clr_k;
  logic mul_start, mul_done;
  logic [2*W-1:0] mul_p;
  logic [W:0] sum;

  function automatic val_t times10(
    input val_t x,
    input val_t dd
  );
    return (x << 3) + (x << 1) + dd;
  endfunction

  assign d     = val_t'(io.key_code);
  assign dig   = io.key_valid && (io.key_code <= 4'd9);
  assign opk   = io.key_valid && (op_t'(key_op(io.key_code)) != OP_NONE);
  assign eq_k  = io.key_valid && (io.key_code == KEY_EQ);
  assign bs_k  = io.key_valid && (io.key_code == KEY_BS);
  assign clr_k = io.key_valid && (io.key_code == KEY_CLR);

  assign sum  = {1'b0, op1} + {1'b0, op2};
  assign lt   = op2 > op1;
  assign diff = lt ? op2 - op1 : op1 - op2;

  calc_mul_seq #(.W(W)) u_mul (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_k),
    .start (mul_start),
    .a     (op1),
    .b     (op2),
    .p     (mul_p),
    .done  (mul_done)
  );

  always_comb begin
    st_n = st;  op1_n = op1;  op2_n = op2;
    cnt1_n = cnt1;  cnt2_n = cnt2;
    op_n = op;  res_n = res;  neg_n = neg;
    rv_n = 1'b0;
    mul_start = 1'b0;
    if (clr_k) begin
      st_n = S_OP1;  op1_n = '0;  op2_n = '0;
      cnt1_n = '0;  cnt2_n = '0;
      op_n = OP_NONE;  res_n = '0;  neg_n = 1'b0;
    end else begin
      unique case (st)
        S_OP1: begin
          if (dig) begin
            if (cnt1 < CMAX) begin
              op1_n  = times10(op1, d);
              cnt1_n = cnt1 + 1'b1;
            end
          end else if (opk) begin
            op_n = key_op(io.key_code);
            st_n = S_OPER;
          end else if (bs_k) begin
            op1_n = op1 / TEN;
            if (cnt1 != '0) cnt1_n = cnt1 - 1'b1;
          end
        end
        S_OPER: begin
          if (opk) begin
            op_n = key_op(io.key_code);
          end else if (dig) begin
            op2_n  = d;
            cnt2_n = cnt_t'(1);
            st_n   = S_OP2;
          end else if (bs_k) begin
            op_n = OP_NONE;
            st_n = S_OP1;
          end
        end
        S_OP2: begin
          if (dig) begin
            if (cnt2 < CMAX) begin
              op2_n  = times10(op2, d);
              cnt2_n = cnt2 + 1'b1;
            end
          end else if (bs_k) begin
            op2_n = op2 / TEN;
            if (cnt2 != '0) cnt2_n = cnt2 - 1'b1;
          end else if (eq_k) begin
            st_n = S_CALC;
            mul_start = (op == OP_MUL);
          end
        end
        S_CALC: begin
          unique case (op)
            OP_MUL: begin
              if (mul_done) begin
                if (mul_p > PMAX) begin
                  st_n = S_ERR;
                end else begin
                  res_n = mul_p[W-1:0];
                  neg_n = 1'b0;
                  st_n  = S_RES;
                  rv_n  = 1'b1;
                end
              end
            end
            OP_SUB: begin
              res_n = diff;
              neg_n = lt;
              st_n  = S_RES;
              rv_n  = 1'b1;
            end
            default: begin
              if (sum > SMAX) begin
                st_n = S_ERR;
              end else begin
                res_n = sum[W-1:0];
                neg_n = 1'b0;
                st_n  = S_RES;
                rv_n  = 1'b1;
              end
            end
          endcase
        end
        S_RES: begin
          if (dig) begin
            op1_n  = d;
            cnt1_n = cnt_t'(1);
            op_n   = OP_NONE;
            neg_n  = 1'b0;
            st_n   = S_OP1;
          end else if (opk && !neg) begin
            // Chained result is locked: no more digits append.
            op1_n  = res;
            cnt1_n = CMAX;
            op_n   = key_op(io.key_code);
            st_n   = S_OPER;
          end
        end
        S_ERR: ;
        default: st_n = S_OP1;
      endcase
    end

    val_n = '0;
    sel_n = SEL_ZERO;
    unique case (st_n)
      S_OP1: begin
        val_n = op1_n;
        sel_n = (cnt1_n == '0 && op1_n == '0)
              ? SEL_ZERO : SEL_OP1;
      end
      S_OPER: begin
        val_n = op1_n;
        sel_n = SEL_OPER;
      end
      S_OP2, S_CALC: begin
        val_n = op2_n;
        sel_n = SEL_OP2;
      end
      S_RES: begin
        val_n = res_n;
        sel_n = SEL_OP2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st   <= S_OP1;
      op1  <= '0;
      op2  <= '0;
      cnt1 <= '0;
      cnt2 <= '0;
      op   <= OP_NONE;
      res  <= '0;
      neg  <= 1'b0;
      io.disp_value <= '0;
      io.disp_neg   <= 1'b0;
      io.disp_op    <= 2'b00;
      io.disp_sel   <= SEL_ZERO;
      io.busy       <= 1'b0;
      io.res_valid  <= 1'b0;
      io.err        <= 1'b0;
    end else begin
      st   <= st_n;
      op1  <= op1_n;
      op2  <= op2_n;
      cnt1 <= cnt1_n;
      cnt2 <= cnt2_n;
      op   <= op_n;
      res  <= res_n;
      neg  <= neg_n;
      io.disp_value <= val_n;
      io.disp_neg   <= neg_n;
      io.disp_op    <= op_n;
      io.disp_sel   <= sel_n;
      io.busy       <= (st_n == S_CALC);
      io.res_valid  <= rv_n;
      io.err        <= (st_n == S_ERR);
    end
  end
endmodule

// File: tb/tb_calc_core.sv
// tb_calc_core: directed and random key streams checked
// every cycle against an integer-level calculator model.
module tb_calc_core;
  localparam int MD = 4;
  localparam int W = 14;
  localparam int MAXV = 9999;

  localparam int P_E1 = 0, P_OPR = 1, P_E2 = 2;
  localparam int P_CALC = 3, P_RES = 4, P_ERR = 5;

  logic clk = 1'b0;
  logic reset;
  int n_chk = 0;
  int n_fail = 0;

  calc_if #(.W(W)) io ();

  calc_core #(.MAX_DIGITS(MD), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  always #5 clk = ~clk;

  int m_ph = P_E1, m_a = 0, m_b = 0;
  int m_na = 0, m_nb = 0, m_op = 0;
  int m_r = 0, m_left = 0;
  bit m_neg = 0, m_rv = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d t=%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic m_clear();
    m_ph = P_E1;  m_a = 0;  m_b = 0;
    m_na = 0;  m_nb = 0;  m_op = 0;
    m_r = 0;  m_neg = 0;  m_rv = 0;  m_left = 0;
  endtask

  task automatic m_tick();
    int r;
    m_left--;
    if (m_left == 0) begin
      case (m_op)
        2: r = m_a - m_b;
        3: r = m_a * m_b;
        default: r = m_a + m_b;
      endcase
      m_neg = (r < 0);
      m_r = (r < 0) ? -r : r;
      if (m_r > MAXV) m_ph = P_ERR;
      else begin
        m_ph = P_RES;
        m_rv = 1;
      end
    end
  endtask

  task automatic m_key(input int k);
    bit isd;
    int kop;
    isd = (k <= 9);
    kop = (k == 10) ? 1 : (k == 11) ? 2 : (k == 14) ? 3 : 0;
    case (m_ph)
      P_E1: begin
        if (isd) begin
          if (m_na < MD) begin
            m_a = m_a * 10 + k;
            m_na++;
          end
        end else if (kop != 0) begin
          m_op = kop;
          m_ph = P_OPR;
        end else if (k == 15) begin
          m_a = m_a / 10;
          if (m_na > 0) m_na--;
        end
      end
      P_OPR: begin
        if (kop != 0) m_op = kop;
        else if (isd) begin
          m_b = k;
          m_nb = 1;
          m_ph = P_E2;
        end else if (k == 15) begin
          m_op = 0;
          m_ph = P_E1;
        end
      end
      P_E2: begin
        if (isd) begin
          if (m_nb < MD) begin
            m_b = m_b * 10 + k;
            m_nb++;
          end
        end else if (k == 15) begin
          m_b = m_b / 10;
          if (m_nb > 0) m_nb--;
        end else if (k == 13) begin
          m_ph = P_CALC;
          m_left = (m_op == 3) ? W + 1 : 1;
        end
      end
      P_RES: begin
        if (isd) begin
          m_a = k;  m_na = 1;  m_op = 0;
          m_neg = 0;  m_ph = P_E1;
        end else if (kop != 0 && !m_neg) begin
          m_a = m_r;  m_na = MD;
          m_op = kop;  m_ph = P_OPR;
        end
      end
      default: ;
    endcase
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) m_clear();
    else begin
      m_rv = 0;
      if (io.key_valid && io.key_code == 4'hC) m_clear();
      else if (m_ph == P_CALC) m_tick();
      else if (io.key_valid) m_key(int'(io.key_code));
    end
  end

  function automatic int e_val();
    case (m_ph)
      P_E1, P_OPR: return m_a;
      P_E2, P_CALC: return m_b;
      P_RES: return m_r;
      default: return 0;
    endcase
  endfunction

  function automatic int e_sel();
    case (m_ph)
      P_E1: return (m_na == 0 && m_a == 0) ? 0 : 1;
      P_OPR: return 2;
      P_E2, P_CALC, P_RES: return 3;
      default: return 0;
    endcase
  endfunction

  always @(negedge clk) begin
    check("value", 32'(io.disp_value), e_val());
    check("neg", 32'(io.disp_neg), 32'(m_neg));
    check("op", 32'(io.disp_op), m_op);
    check("sel", 32'(io.disp_sel), e_sel());
    check("busy", 32'(io.busy), 32'(m_ph == P_CALC));
    check("res_valid", 32'(io.res_valid), 32'(m_rv));
    check("err", 32'(io.err), 32'(m_ph == P_ERR));
  end

  task automatic key(input logic [3:0] c);
    @(negedge clk);
    #1;
    io.key_valid = 1'b1;
    io.key_code = c;
    @(negedge clk);
    #1;
    io.key_valid = 1'b0;
  endtask

  task automatic keys(input logic [3:0] s[$]);
    foreach (s[i]) key(s[i]);
  endtask

  task automatic watch(input int n, output int bc,
                       output int rc, output int first);
    bc = 0;
    rc = 0;
    first = -1;
    for (int i = 0; i < n; i++) begin
      if (io.busy) bc++;
      if (io.res_valid) begin
        rc++;
        if (first < 0) first = i;
      end
      @(negedge clk);
    end
  endtask

  function automatic logic [3:0] pick();
    int r;
    r = $urandom_range(0, 99);
    if (r < 55) return 4'(r % 10);
    if (r < 62) return 4'hA;
    if (r < 69) return 4'hB;
    if (r < 76) return 4'hE;
    if (r < 88) return 4'hD;
    if (r < 96) return 4'hF;
    return 4'hC;
  endfunction

  int bc, rc, first;

  initial begin
    reset = 1'b1;
    io.key_valid = 1'b0;
    io.key_code = 4'h0;
    @(negedge clk);
    check("rst_value", 32'(io.disp_value), 0);
    check("rst_sel", 32'(io.disp_sel), 0);
    #2 reset = 1'b0;

    keys('{4'h1, 4'h2, 4'hA, 4'h3, 4'h4, 4'hD});
    watch(W + 5, bc, rc, first);
    check("add_lat", first, 1);
    check("add_rv", rc, 1);
    check("add_val", 32'(io.disp_value), 46);
    check("add_op", 32'(io.disp_op), 1);
    check("add_sel", 32'(io.disp_sel), 3);

    keys('{4'hC, 4'h5, 4'hB, 4'h9, 4'hD});
    watch(4, bc, rc, first);
    check("sub_val", 32'(io.disp_value), 4);
    check("sub_neg", 32'(io.disp_neg), 1);
    key(4'hA);
    check("sub_hold_sel", 32'(io.disp_sel), 3);
    check("sub_hold_op", 32'(io.disp_op), 2);

    keys('{4'hC, 4'h9, 4'h9, 4'hE, 4'h9, 4'h9, 4'hD});
    watch(W + 5, bc, rc, first);
    check("mul_busy", bc, W + 1);
    check("mul_rv", rc, 1);
    check("mul_lat", first, W + 1);
    check("mul_val", 32'(io.disp_value), 9801);
    check("mul_err", 32'(io.err), 0);

    keys('{4'hC, 4'h9, 4'h9, 4'h9, 4'h9, 4'hA, 4'h1, 4'hD});
    watch(4, bc, rc, first);
    check("ovf_rv", rc, 0);
    check("ovf_err", 32'(io.err), 1);
    key(4'h5);
    check("ovf_val", 32'(io.disp_value), 0);
    check("ovf_err2", 32'(io.err), 1);
    key(4'hC);
    check("clr_err", 32'(io.err), 0);
    check("clr_sel", 32'(io.disp_sel), 0);

    keys('{4'h1, 4'h2, 4'h3, 4'h4, 4'h5});
    check("trunc_val", 32'(io.disp_value), 1234);
    key(4'hF);
    check("bs_val", 32'(io.disp_value), 123);
    keys('{4'hA, 4'hF});
    check("bs_op_sel", 32'(io.disp_sel), 1);
    check("bs_op_val", 32'(io.disp_value), 123);
    check("bs_op_op", 32'(io.disp_op), 0);

    keys('{4'hC, 4'h7, 4'hE, 4'h8, 4'hD});
    @(negedge clk);
    key(4'hC);
    watch(W + 5, bc, rc, first);
    check("abort_rv", rc, 0);
    check("abort_busy", bc, 0);
    check("abort_val", 32'(io.disp_value), 0);

    keys('{4'h1, 4'h2});
    @(negedge clk);
    #2;
    reset = 1'b1;
    io.key_valid = 1'b1;
    io.key_code = 4'h3;
    @(negedge clk);
    check("rst_mid_val", 32'(io.disp_value), 0);
    check("rst_mid_sel", 32'(io.disp_sel), 0);
    #2;
    reset = 1'b0;
    io.key_valid = 1'b0;

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      #1;
      io.key_valid = ($urandom_range(0, 2) == 0);
      io.key_code = pick();
    end
    @(negedge clk);
    #1;
    io.key_valid = 1'b0;
    repeat (W + 4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
